// File: rtl/video_timing_ctrl_pkg.sv
// Shared types, default raster timing and window-decode helpers for the video timing generator.
package video_timing_pkg;

  typedef logic [8:0] count_t;

  localparam count_t DEF_H_START  = 9'h0C0;
  localparam count_t DEF_H_END    = 9'h1FF;
  localparam count_t DEF_HB_START = 9'h1F0;
  localparam count_t DEF_HB_END   = 9'h0F0;
  localparam count_t DEF_HS_START = 9'h0D0;
  localparam count_t DEF_HS_END   = 9'h0F0;
  localparam count_t DEF_V_START  = 9'h0F8;
  localparam count_t DEF_V_END    = 9'h1FF;
  localparam count_t DEF_VB_START = 9'h1F0;
  localparam count_t DEF_VB_END   = 9'h110;
  localparam count_t DEF_VS_START = 9'h0F8;
  localparam count_t DEF_VS_END   = 9'h100;

  // Static membership test, used only to seed flags at reset; windows may wrap.
  function automatic logic in_window(count_t start, count_t stop, count_t cnt);
    if (start == stop) return 1'b0;
    if (start < stop) return (cnt >= start) && (cnt < stop);
    return (cnt >= start) || (cnt < stop);
  endfunction

  function automatic logic window_next(count_t start, count_t stop, count_t next_cnt,
                                       logic cur_flag);
    logic flag;
    flag = cur_flag;
    if (start != stop) begin
      if (next_cnt == start) flag = 1'b1;
      else if (next_cnt == stop) flag = 1'b0;
    end
    return flag;
  endfunction

endpackage

// File: rtl/video_timing_ctrl_if.sv
// Raster timing bundle: pixel enable in, counts, flags and strobes out.
interface video_timing_ctrl_if;
  import video_timing_pkg::*;

  logic   ce_pix;
  count_t hcnt;
  count_t vcnt;
  logic   hblank;
  logic   vblank;
  logic   hsync;
  logic   vsync;
  logic   line_end;
  logic   frame_end;

  modport master (
    input  ce_pix,
    output hcnt, vcnt, hblank, vblank, hsync, vsync, line_end, frame_end
  );

  modport slave (
    output ce_pix,
    input  hcnt, vcnt, hblank, vblank, hsync, vsync, line_end, frame_end
  );
endinterface

// File: rtl/video_timing_ctrl_ls161.sv
// 74161-equivalent 4-bit synchronous counter: clear, parallel load, count on enp&ent, ripple carry.
module video_timing_ctrl_ls161 (
  input  logic       clk,
  input  logic       cl_n,
  input  logic       ld_n,
  input  logic       enp,
  input  logic       ent,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       rco
);
  logic [3:0] q_q;

  always_ff @(posedge clk) begin
    if (!cl_n) begin
      q_q <= 4'h0;
    end else if (!ld_n) begin
      q_q <= d;
    end else if (enp && ent) begin
      q_q <= q_q + 4'd1;
    end
  end

  assign q   = q_q;
  assign rco = ent & (q_q == 4'hF);
endmodule

// File: rtl/video_timing_ctrl.sv
// Raster timing generator: cascaded 74161 H/V counters with preset-on-terminal-count and
// zero-skew registered blank/sync flags.
module video_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter count_t H_START  = DEF_H_START,
  parameter count_t H_END    = DEF_H_END,
  parameter count_t HB_START = DEF_HB_START,
  parameter count_t HB_END   = DEF_HB_END,
  parameter count_t HS_START = DEF_HS_START,
  parameter count_t HS_END   = DEF_HS_END,
  parameter count_t V_START  = DEF_V_START,
  parameter count_t V_END    = DEF_V_END,
  parameter count_t VB_START = DEF_VB_START,
  parameter count_t VB_END   = DEF_VB_END,
  parameter count_t VS_START = DEF_VS_START,
  parameter count_t VS_END   = DEF_VS_END
) (
  input  logic                clk,
  input  logic                reset,
  video_timing_ctrl_if.master vif
);
  localparam logic [11:0] H_PRESET = {3'b000, H_START};
  localparam logic [11:0] V_PRESET = {3'b000, V_START};

  logic [11:0] h_q, v_q;
  logic [3:0]  h_en, v_en;
  logic        h_ld_n, v_ld_n;
  logic        line_end, frame_end;
  count_t      hcnt_q, vcnt_q, hcnt_d, vcnt_d;
  logic        hblank_q, vblank_q, hsync_q, vsync_q;

  assign hcnt_q    = h_q[8:0];
  assign vcnt_q    = v_q[8:0];
  assign line_end  = vif.ce_pix & (hcnt_q == H_END);
  assign frame_end = line_end & (vcnt_q == V_END);

  // Reset is folded into the parallel load so the counters need no clear path.
  assign h_ld_n = ~(reset | line_end);
  assign v_ld_n = ~(reset | frame_end);
  assign h_en[0] = vif.ce_pix;
  assign v_en[0] = line_end;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_stage
      video_timing_ctrl_ls161 u_h (
        .clk (clk), .cl_n(1'b1), .ld_n(h_ld_n), .enp(h_en[gi]), .ent(h_en[gi]),
        .d   (H_PRESET[4*gi +: 4]), .q(h_q[4*gi +: 4]), .rco(h_en[gi+1])
      );
      video_timing_ctrl_ls161 u_v (
        .clk (clk), .cl_n(1'b1), .ld_n(v_ld_n), .enp(v_en[gi]), .ent(v_en[gi]),
        .d   (V_PRESET[4*gi +: 4]), .q(v_q[4*gi +: 4]), .rco(v_en[gi+1])
      );
    end
  endgenerate

  // Top three counter bits and final carries only matter beyond the 9-bit raster.
  logic unused_bits;
  assign unused_bits = ^{h_q[11:9], v_q[11:9], h_en[3], v_en[3]};

  // Mirror of what the counters will hold after this edge, so flags land with the count.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (line_end) begin
      hcnt_d = H_START;
      vcnt_d = frame_end ? V_START : count_t'(vcnt_q + 9'd1);
    end else if (vif.ce_pix) begin
      hcnt_d = count_t'(hcnt_q + 9'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hblank_q <= in_window(HB_START, HB_END, H_START);
      hsync_q  <= in_window(HS_START, HS_END, H_START);
      vblank_q <= in_window(VB_START, VB_END, V_START);
      vsync_q  <= in_window(VS_START, VS_END, V_START);
    end else if (vif.ce_pix) begin
      hblank_q <= window_next(HB_START, HB_END, hcnt_d, hblank_q);
      hsync_q  <= window_next(HS_START, HS_END, hcnt_d, hsync_q);
      vblank_q <= window_next(VB_START, VB_END, vcnt_d, vblank_q);
      vsync_q  <= window_next(VS_START, VS_END, vcnt_d, vsync_q);
    end
  end

  assign vif.hcnt      = hcnt_q;
  assign vif.vcnt      = vcnt_q;
  assign vif.hblank    = hblank_q;
  assign vif.vblank    = vblank_q;
  assign vif.hsync     = hsync_q;
  assign vif.vsync     = vsync_q;
  assign vif.line_end  = line_end;
  assign vif.frame_end = frame_end;
endmodule

// File: tb/tb_video_timing_ctrl.sv
// Scoreboarded bench for video_timing_ctrl: a reference raster model predicts every clock,
// scenario tasks add counting checks on periods, widths and strobes.
module tb_video_timing_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  video_timing_ctrl_if vif ();

  video_timing_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .vif  (vif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] h;
    logic [8:0] v;
    logic hb, vb, hs, vs, le, fe;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [8:0] hm, vm;

  // Scenario accumulators
  int le_cnt, fe_cnt, hs_cnt, hb_low, vs_lines, vb_low_lines;

  function automatic logic m_hblank(logic [8:0] h);
    return !(h >= 9'h0F0 && h < 9'h1F0);
  endfunction
  function automatic logic m_hsync(logic [8:0] h);
    return (h >= 9'h0D0 && h < 9'h0F0);
  endfunction
  function automatic logic m_vblank(logic [8:0] v);
    return !(v >= 9'h110 && v < 9'h1F0);
  endfunction
  function automatic logic m_vsync(logic [8:0] v);
    return (v >= 9'h0F8 && v < 9'h100);
  endfunction

  // Monitor: each edge's DUT state is popped against the model's prediction.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      total++; if (vif.hcnt !== e.h) begin bad++; $display("FAIL sb_hcnt t=%0t got=%h want=%h", $time, vif.hcnt, e.h); end
      total++; if (vif.vcnt !== e.v) begin bad++; $display("FAIL sb_vcnt t=%0t got=%h want=%h", $time, vif.vcnt, e.v); end
      total++; if (vif.hblank !== e.hb) begin bad++; $display("FAIL sb_hblank t=%0t got=%b want=%b", $time, vif.hblank, e.hb); end
      total++; if (vif.vblank !== e.vb) begin bad++; $display("FAIL sb_vblank t=%0t got=%b want=%b", $time, vif.vblank, e.vb); end
      total++; if (vif.hsync !== e.hs) begin bad++; $display("FAIL sb_hsync t=%0t got=%b want=%b", $time, vif.hsync, e.hs); end
      total++; if (vif.vsync !== e.vs) begin bad++; $display("FAIL sb_vsync t=%0t got=%b want=%b", $time, vif.vsync, e.vs); end
      total++; if (vif.line_end !== e.le) begin bad++; $display("FAIL sb_line_end t=%0t got=%b want=%b", $time, vif.line_end, e.le); end
      total++; if (vif.frame_end !== e.fe) begin bad++; $display("FAIL sb_frame_end t=%0t got=%b want=%b", $time, vif.frame_end, e.fe); end
    end
  end

  // Drive inputs for the next edge and push the model's prediction for that edge.
  task automatic tick(input logic ce, input logic rst);
    exp_t x;
    @(posedge clk);
    #2;
    vif.ce_pix = ce;
    reset      = rst;
    if (rst) begin
      hm = 9'h0C0;
      vm = 9'h0F8;
    end else if (ce) begin
      if (hm == 9'h1FF) begin
        hm = 9'h0C0;
        vm = (vm == 9'h1FF) ? 9'h0F8 : vm + 9'd1;
      end else begin
        hm = hm + 9'd1;
      end
    end
    x.h  = hm;
    x.v  = vm;
    x.hb = m_hblank(hm);
    x.vb = m_vblank(vm);
    x.hs = m_hsync(hm);
    x.vs = m_vsync(vm);
    x.le = ce & (hm == 9'h1FF);
    x.fe = x.le & (vm == 9'h1FF);
    sb.push_back(x);
    #1;
  endtask

  task automatic accumulate();
    if (vif.hsync) hs_cnt++;
    if (!vif.hblank) hb_low++;
    if (vif.line_end) le_cnt++;
    if (vif.frame_end) fe_cnt++;
    if (vif.line_end && vif.vsync) vs_lines++;
    if (vif.line_end && !vif.vblank) vb_low_lines++;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    total++; if (vif.hcnt !== 9'h0C0) begin bad++; $display("FAIL reset_hcnt got=%h want=0c0", vif.hcnt); end
    total++; if (vif.vcnt !== 9'h0F8) begin bad++; $display("FAIL reset_vcnt got=%h want=0f8", vif.vcnt); end
    total++; if ({vif.hblank, vif.vblank, vif.hsync, vif.vsync} !== 4'b1101) begin
      bad++; $display("FAIL reset_flags got=%b want=1101", {vif.hblank, vif.vblank, vif.hsync, vif.vsync});
    end
    $display("test_reset: hcnt=%h vcnt=%h", vif.hcnt, vif.vcnt);
  endtask

  task automatic test_line();
    le_cnt = 0; fe_cnt = 0; hs_cnt = 0; hb_low = 0; vs_lines = 0; vb_low_lines = 0;
    for (int i = 0; i < 320; i++) begin
      tick(1'b1, 1'b0);
      accumulate();
    end
    total++; if (le_cnt != 1) begin bad++; $display("FAIL line_end_per_line got=%0d want=1", le_cnt); end
    total++; if (hs_cnt != 32) begin bad++; $display("FAIL hsync_width got=%0d want=32", hs_cnt); end
    total++; if (hb_low != 256) begin bad++; $display("FAIL hblank_low got=%0d want=256", hb_low); end
    total++; if (vif.hcnt !== 9'h1FF) begin bad++; $display("FAIL line_last_hcnt got=%h want=1ff", vif.hcnt); end
    $display("test_line: line_end=%0d hsync=%0d hblank_low=%0d", le_cnt, hs_cnt, hb_low);
  endtask

  task automatic test_frame();
    // Continues the line already sampled so the counts cover one whole frame.
    for (int i = 0; i < 84480 - 320; i++) begin
      tick(1'b1, 1'b0);
      accumulate();
    end
    total++; if (fe_cnt != 1) begin bad++; $display("FAIL frame_end_per_frame got=%0d want=1", fe_cnt); end
    total++; if (le_cnt != 264) begin bad++; $display("FAIL lines_per_frame got=%0d want=264", le_cnt); end
    total++; if (vs_lines != 8) begin bad++; $display("FAIL vsync_lines got=%0d want=8", vs_lines); end
    total++; if (vb_low_lines != 224) begin bad++; $display("FAIL vblank_low_lines got=%0d want=224", vb_low_lines); end
    total++; if (vif.vcnt !== 9'h1FF) begin bad++; $display("FAIL frame_last_vcnt got=%h want=1ff", vif.vcnt); end
    total++; if (vif.frame_end !== 1'b1) begin bad++; $display("FAIL frame_end_at_last got=%b want=1", vif.frame_end); end
    $display("test_frame: frame_end=%0d lines=%0d vsync_lines=%0d", fe_cnt, le_cnt, vs_lines);
  endtask

  task automatic test_ce_quarter();
    le_cnt = 0;
    for (int i = 0; i < 1280; i++) begin
      tick((i % 4) == 0, 1'b0);
      if (vif.line_end) le_cnt++;
    end
    total++; if (le_cnt != 1) begin bad++; $display("FAIL quarter_line_end got=%0d want=1", le_cnt); end
    total++; if (vif.hcnt !== 9'h0C0) begin bad++; $display("FAIL quarter_hcnt got=%h want=0c0", vif.hcnt); end
    total++; if (vif.vcnt !== 9'h0F9) begin bad++; $display("FAIL quarter_vcnt got=%h want=0f9", vif.vcnt); end
    $display("test_ce_quarter: hcnt=%h vcnt=%h", vif.hcnt, vif.vcnt);
  endtask

  task automatic test_hold();
    int n;
    n = 0;
    while (vif.hcnt !== 9'h1FE && n < 400) begin
      tick(1'b1, 1'b0);
      n++;
    end
    total++; if (vif.hcnt !== 9'h1FE) begin bad++; $display("FAIL hold_reach got=%h want=1fe", vif.hcnt); end
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0);
      total++; if (vif.hcnt !== 9'h1FF || vif.line_end !== 1'b0) begin
        bad++; $display("FAIL hold_idle got=%h/%b want=1ff/0", vif.hcnt, vif.line_end);
      end
    end
    tick(1'b1, 1'b0);
    total++; if (vif.line_end !== 1'b1) begin bad++; $display("FAIL hold_reassert_strobe got=%b want=1", vif.line_end); end
    tick(1'b0, 1'b0);
    total++; if (vif.hcnt !== 9'h0C0 || vif.vcnt !== 9'h0FA) begin
      bad++; $display("FAIL hold_wrap got=%h/%h want=0c0/0fa", vif.hcnt, vif.vcnt);
    end
    $display("test_hold: hcnt=%h vcnt=%h", vif.hcnt, vif.vcnt);
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (vif.hcnt !== 9'h14F && n < 400) begin
      tick(1'b1, 1'b0);
      n++;
    end
    tick(1'b1, 1'b1);
    total++; if (vif.hcnt !== 9'h150) begin bad++; $display("FAIL mid_reach got=%h want=150", vif.hcnt); end
    tick(1'b1, 1'b0);
    total++; if (vif.hcnt !== 9'h0C0 || vif.vcnt !== 9'h0F8) begin
      bad++; $display("FAIL mid_reset_cnt got=%h/%h want=0c0/0f8", vif.hcnt, vif.vcnt);
    end
    total++; if ({vif.hblank, vif.vblank, vif.hsync, vif.vsync} !== 4'b1101) begin
      bad++; $display("FAIL mid_reset_flags got=%b want=1101", {vif.hblank, vif.vblank, vif.hsync, vif.vsync});
    end
    $display("test_reset_mid: hcnt=%h vcnt=%h", vif.hcnt, vif.vcnt);
  endtask

  initial begin
    reset      = 1'b1;
    vif.ce_pix = 1'b0;
    hm         = 9'h0C0;
    vm         = 9'h0F8;
    test_reset();
    test_line();
    test_frame();
    test_ce_quarter();
    test_hold();
    test_reset_mid();
    tick(1'b0, 1'b0);
    @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
